// File: rtl/lsu_dmem_initiator.sv
// Load/store initiator: turns one execute-stage request into a masked data-memory access.
// Optional alignment checking is enabled by defining LSU_MISALIGN_CHK_EN.
module lsu_dmem_initiator #(
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_base,
    input  logic [31:0] req_offset,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_mask,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    output logic        mem_cs,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt;
    logic        store_q;
    logic        accept;
    logic        last_access;
    logic [31:0] eff;
    logic [1:0]  off;
    logic        illegal;
    logic        align_err;
    logic        err;
    logic [3:0]  mask_enc;
    logic [31:0] wdata_enc;

    assign accept      = req_valid && req_ready;
    assign eff         = req_base + req_offset;
    assign off         = eff[1:0];
    assign last_access = (wait_cnt == 4'(WAIT_CYCLES));
    assign req_ready   = (state == IDLE);
    assign resp_valid  = (state == RESP);

    // Size/lane decode; the mask codes are what the memory uses to pick and extend lanes.
    always_comb begin
        illegal   = 1'b0;
        mask_enc  = 4'd0;
        wdata_enc = req_wdata;
        case (req_funct3)
            3'b000: begin
                mask_enc  = {2'b00, off};
                wdata_enc = {24'b0, req_wdata[7:0]} << {off, 3'b000};
            end
            3'b001: begin
                mask_enc  = 4'd4 + {3'b000, off[1]};
                wdata_enc = off[1] ? {req_wdata[15:0], 16'b0} : {16'b0, req_wdata[15:0]};
            end
            3'b010: mask_enc = 4'd6;
            3'b100: begin
                mask_enc = 4'd7 + {2'b00, off};
                illegal  = req_is_store;
            end
            3'b101: begin
                mask_enc = 4'd11 + {3'b000, off[1]};
                illegal  = req_is_store;
            end
            default: illegal = 1'b1;
        endcase
    end

`ifdef LSU_MISALIGN_CHK_EN
    assign align_err = ((req_funct3[1:0] == 2'b01) && off[0]) ||
                       ((req_funct3 == 3'b010) && (off != 2'b00));
`else
    // Halfword/word accesses silently drop the low address bits.
    assign align_err = 1'b0;
`endif

    assign err = illegal || align_err;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = err ? RESP : ACCESS;
            ACCESS:  if (last_access) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt       <= 4'd0;
            store_q        <= 1'b0;
            resp_err       <= 1'b0;
            resp_rdata     <= 32'd0;
            mem_addr       <= 32'd0;
            mem_write_data <= 32'd0;
            mem_mask       <= 4'd0;
            mem_rd_en      <= 1'b0;
            mem_wr_en      <= 1'b1;
            mem_cs         <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        wait_cnt   <= 4'd0;
                        resp_err   <= err;
                        resp_rdata <= 32'd0;
                        store_q    <= req_is_store;
                        if (!err) begin
                            mem_addr       <= {eff[31:2], 2'b00};
                            mem_mask       <= mask_enc;
                            mem_write_data <= wdata_enc;
                            mem_cs         <= 1'b0;
                            mem_rd_en      <= !req_is_store;
                            mem_wr_en      <= !req_is_store;
                        end
                    end
                end
                ACCESS: begin
                    if (last_access) begin
                        mem_cs    <= 1'b1;
                        mem_rd_en <= 1'b0;
                        mem_wr_en <= 1'b1;
                        if (!store_q) resp_rdata <= mem_read_data;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                RESP:    resp_err <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dmem_initiator.sv
// Randomized scoreboard bench for lsu_dmem_initiator with a behavioural memory and request model.
module tb_lsu_dmem_initiator;
    localparam int W = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_base = 32'd0;
    logic [31:0] req_offset = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_mask;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic        mem_cs;
    logic [31:0] mem_read_data;

    lsu_dmem_initiator #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_funct3(req_funct3), .req_base(req_base),
        .req_offset(req_offset), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_err(resp_err), .resp_rdata(resp_rdata), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_mask(mem_mask), .mem_rd_en(mem_rd_en),
        .mem_wr_en(mem_wr_en), .mem_cs(mem_cs), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          err;
        bit          st;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        int          due;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_acc = 0;
    bit   last_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // The memory returns an already-extended word that depends on address and lane code.
    function automatic logic [31:0] memf(input logic [31:0] a, input logic [3:0] m);
        return {a[23:0], 4'h0, m} ^ 32'hC3A5_96F0;
    endfunction

    assign mem_read_data = memf(mem_addr, mem_mask);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input bit st, input bit [2:0] f3, input logic [31:0] b,
                                   input logic [31:0] o, input logic [31:0] wd, input int acc);
        exp_t        e;
        logic [31:0] eff;
        int          off;
        bit          bad;
        eff = b + o;
        off = int'(eff % 4);
        bad = (f3 == 3) || (f3 >= 6) || (st && f3 >= 4);
`ifdef LSU_MISALIGN_CHK_EN
        if ((f3 == 1 || f3 == 5) && (off % 2 == 1)) bad = 1'b1;
        if (f3 == 2 && off != 0) bad = 1'b1;
`endif
        e.err   = bad;
        e.st    = st;
        e.addr  = eff - 32'(off);
        case (f3)
            3'd0: e.mask = 4'(off);
            3'd1: e.mask = 4'(4 + off / 2);
            3'd2: e.mask = 4'd6;
            3'd4: e.mask = 4'(7 + off);
            3'd5: e.mask = 4'(11 + off / 2);
            default: e.mask = 4'd0;
        endcase
        case (f3)
            3'd0:    e.wdata = (wd & 32'hFF) << (8 * off);
            3'd1:    e.wdata = (wd & 32'hFFFF) << (16 * (off / 2));
            default: e.wdata = wd;
        endcase
        e.rdata = (bad || st) ? 32'd0 : memf(e.addr, e.mask);
        e.due   = acc + (bad ? 1 : W + 2);
        return e;
    endfunction

    task automatic issue(input bit st, input bit [2:0] f3, input logic [31:0] b,
                         input logic [31:0] o, input logic [31:0] wd, input bit b2b);
        int   waited = 0;
        exp_t e;
        @(negedge clk);
        req_is_store = st;
        req_funct3   = f3;
        req_base     = b;
        req_offset   = o;
        req_wdata    = wd;
        req_valid    = 1'b1;
        if (b2b) chk("busy_ready", 32'(req_ready), 32'd0);
        while (!req_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        e = model(st, f3, b, o, wd, cyc);
        if (b2b) chk("throughput", 32'(cyc), 32'(last_acc + (last_err ? 2 : W + 3)));
        q.push_back(e);
        last_acc = cyc;
        last_err = e.err;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    // Monitor: tracks each strobe window and pops the scoreboard on every response pulse.
    initial begin
        int          acc_n = 0;
        bit          unstable = 1'b0;
        logic [31:0] a_addr = 32'd0, a_wd = 32'd0;
        logic [3:0]  a_mask = 4'd0;
        logic        a_rd = 1'b0, a_wr = 1'b1;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (reset) begin
                acc_n    = 0;
                unstable = 1'b0;
            end else begin
                if (mem_cs === 1'b0) begin
                    if (acc_n == 0) begin
                        a_addr = mem_addr; a_wd = mem_write_data; a_mask = mem_mask;
                        a_rd = mem_rd_en; a_wr = mem_wr_en;
                    end else if (a_addr !== mem_addr || a_wd !== mem_write_data ||
                                 a_mask !== mem_mask || a_rd !== mem_rd_en || a_wr !== mem_wr_en) begin
                        unstable = 1'b1;
                    end
                    acc_n++;
                end else begin
                    chk("idle_strobes", {30'd0, mem_rd_en, mem_wr_en}, 32'd1);
                end
                if (resp_valid === 1'b1) begin
                    if (q.size() == 0) begin
                        chk("spurious_resp", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("resp_err", 32'(resp_err), 32'(e.err));
                        chk("resp_rdata", resp_rdata, e.rdata);
                        chk("resp_latency", 32'(cyc), 32'(e.due));
                        if (e.err) begin
                            chk("err_no_access", 32'(acc_n), 32'd0);
                        end else begin
                            chk("access_len", 32'(acc_n), 32'(W + 1));
                            chk("mem_mask", 32'(a_mask), 32'(e.mask));
                            chk("mem_addr", a_addr, e.addr);
                            chk("mem_rd_en", 32'(a_rd), 32'(!e.st));
                            chk("mem_wr_en", 32'(a_wr), 32'(!e.st));
                            if (e.st) chk("mem_write_data", a_wd, e.wdata);
                            chk("access_stable", 32'(unstable), 32'd0);
                        end
                    end
                    acc_n    = 0;
                    unstable = 1'b0;
                end
            end
        end
    end

    initial begin
        bit          st;
        bit [2:0]    f3;
        int          gap;
        bit [2:0]    legal_f3[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_write_data, 32'd0);
        chk("rst_mem_mask", 32'(mem_mask), 32'd0);
        chk("rst_strobes", {29'd0, mem_rd_en, mem_wr_en, mem_cs}, 32'd3);
        reset = 1'b0;

        // Directed corner cases, then a back-to-back illegal request held during a load.
        issue(1'b0, 3'b000, 32'h10, 32'h3, 32'h0, 1'b0);
        issue(1'b1, 3'b001, 32'h20, 32'h2, 32'h1234ABCD, 1'b1);
        issue(1'b0, 3'b010, 32'h40, 32'h1, 32'h0, 1'b1);
        issue(1'b0, 3'b101, 32'h8, 32'hFFFF_FFFE, 32'h0, 1'b1);
        issue(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1);
        issue(1'b1, 3'b100, 32'h103, 32'h0, 32'h55, 1'b1);
        issue(1'b1, 3'b000, 32'hFFFF_FFFF, 32'h4, 32'hA5, 1'b1);
        issue(1'b1, 3'b010, 32'h7F0, 32'h8, 32'hDEADBEEF, 1'b1);

        for (int i = 0; i < 300; i++) begin
            st  = 1'($urandom_range(0, 1));
            f3  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : legal_f3[$urandom_range(0, 4)];
            gap = $urandom_range(0, 2);
            repeat (gap) @(posedge clk);
            issue(st, f3, $urandom, 32'($signed(12'($urandom))), $urandom, gap == 0);
        end
        drain();

        // Reset during the first access cycle of a load: no response, strobes released.
        @(negedge clk);
        req_is_store = 1'b0; req_funct3 = 3'b010; req_base = 32'h200; req_offset = 32'h0;
        req_valid = 1'b1;
        chk("rstmid_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_cs_active", 32'(mem_cs), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_cs", 32'(mem_cs), 32'd1);
        chk("rstmid_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rstmid_ready_after", 32'(req_ready), 32'd1);
        chk("rstmid_resp_valid", 32'(resp_valid), 32'd0);
        reset = 1'b0;
        repeat (W + 4) @(negedge clk);
        chk("rstmid_no_resp", 32'(resp_valid), 32'd0);

        issue(1'b0, 3'b100, 32'h300, 32'h2, 32'h0, 1'b0);
        drain();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
